dcache_dm: RTL and testbench

Parametrised direct-mapped, write-through, no-write-allocate data cache for the core's load/store path. It sits between the core's memory stage and a slower word-wide backing memory. Both sides use request/acknowledge handshakes. It supports the RISC-V funct3 load/store modes (B, H, W, BU, HU) with big-endian byte order: the lowest address holds the most-significant byte. Misaligned and illegal accesses return a fault instead of touching memory.

---
 rtl/dcache_dm.sv | 194 +++++++++++++++++++
 tb/tb_dcache_dm.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with big-endian
// RISC-V load/store formatting and a word-wide, beat-by-beat line refill.
module dcache_dm #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 16,
    parameter int LINES      = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [2:0]        req_mode,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int WORDS  = LINE_BYTES / 4;
    localparam int BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int WIDX_W = IDX_W + OFF_W - 2;

    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, STORE, RESP} state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [2:0]        r_mode;
    logic [31:0]       r_wdata;
    logic [31:0]       resp_data_q;
    logic              resp_fault_q;
    logic [BEAT_W-1:0] beat_q;
    logic              gap_q;

    logic [31:0]      data_q [LINES*WORDS];
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [LINES-1:0] valid_q;

    logic [IDX_W-1:0]  line_idx;
    logic [TAG_W-1:0]  line_tag;
    logic [1:0]        off;
    logic [WIDX_W-1:0] lookup_widx;
    logic [WIDX_W-1:0] refill_widx;
    logic [31:0]       word;
    logic              hit;
    logic              fault;
    logic              mem_done;
    logic              last_beat;
    logic [7:0]        load_byte;
    logic [15:0]       load_half;
    logic [31:0]       load_data;
    logic [3:0]        st_be;
    logic [31:0]       st_data;
    logic [31:0]       merged;

    assign line_idx    = r_addr[OFF_W+IDX_W-1:OFF_W];
    assign line_tag    = r_addr[ADDR_W-1:OFF_W+IDX_W];
    assign off         = r_addr[1:0];
    assign lookup_widx = r_addr[OFF_W+IDX_W-1:2];
    assign refill_widx = WIDX_W'(int'(line_idx) * WORDS + int'(beat_q));
    assign word        = data_q[lookup_widx];
    assign hit         = valid_q[line_idx] && (tag_q[line_idx] == line_tag);
    assign mem_done    = mem_req && mem_ack;
    assign last_beat   = (beat_q == BEAT_W'(WORDS - 1));

    // Illegal funct3, unsigned stores and misaligned H/W all fault before any side effect.
    assign fault = (r_mode == 3'b011) || (r_mode[2:1] == 2'b11) || (r_write && r_mode[2]) ||
                   ((r_mode[1:0] == 2'b01) && off[0]) ||
                   ((r_mode == 3'b010) && (off != 2'b00));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        load_byte = word[8*(3-int'(off)) +: 8];
        load_half = off[1] ? word[15:0] : word[31:16];
        case (r_mode)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'b0, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'b0, load_half};
            default: load_data = word;
        endcase
    end

    // Store lanes: byte at offset o sits in bits [31-8o -: 8], enable bit 3-o.
    always_comb begin
        st_be   = 4'b1111;
        st_data = r_wdata;
        case (r_mode[1:0])
            2'b00: begin
                st_be   = 4'b1000 >> off;
                st_data = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                st_be   = off[1] ? 4'b0011 : 4'b1100;
                st_data = {2{r_wdata[15:0]}};
            end
            default: ;
        endcase
        merged = word;
        for (int i = 0; i < 4; i++) begin
            if (st_be[i]) merged[8*i +: 8] = st_data[8*i +: 8];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = LOOKUP;
            LOOKUP: begin
                if (fault)        state_nxt = RESP;
                else if (r_write) state_nxt = STORE;
                else if (hit)     state_nxt = RESP;
                else              state_nxt = REFILL;
            end
            REFILL:  if (mem_done && last_beat) state_nxt = LOOKUP;
            STORE:   if (mem_done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_rdata = resp_valid ? resp_data_q : 32'b0;
        resp_fault = resp_valid && resp_fault_q;
        mem_req    = ((state == REFILL) && !gap_q) || (state == STORE);
        mem_we     = (state == STORE);
        mem_addr   = '0;
        mem_wdata  = 32'b0;
        mem_be     = 4'b0000;
        if (state == REFILL) begin
            mem_addr = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} | (ADDR_W'(beat_q) << 2);
            mem_be   = 4'b1111;
        end else if (state == STORE) begin
            mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
            mem_wdata = st_data;
            mem_be    = st_be;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            r_addr  <= req_addr;
            r_write <= req_write;
            r_mode  <= req_mode;
            r_wdata <= req_wdata;
        end
        if (state == LOOKUP) begin
            resp_fault_q <= fault;
            resp_data_q  <= (fault || r_write) ? 32'b0 : load_data;
            beat_q       <= '0;
            gap_q        <= 1'b0;
        end else if (state == REFILL) begin
            // mem_req drops for one cycle after every accepted beat.
            gap_q <= mem_done;
            if (mem_done) beat_q <= beat_q + BEAT_W'(1);
        end
    end

    // NOTE: data and tag arrays are not reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (state == REFILL && mem_done) begin
            data_q[refill_widx] <= mem_rdata;
            if (last_beat) tag_q[line_idx] <= line_tag;
        end else if (state == LOOKUP && r_write && hit && !fault) begin
            data_q[lookup_widx] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                                           valid_q <= '0;
        else if (state == REFILL && mem_done && last_beat) valid_q[line_idx] <= 1'b1;
    end

endmodule

// File: tb/tb_dcache_dm.sv
// Self-checking bench for dcache_dm: directed scenarios then random traffic
// checked against a byte-level memory model and a line-presence model.
module tb_dcache_dm;
    localparam int ADDR_W     = 32;
    localparam int LINE_BYTES = 16;
    localparam int LINES      = 64;
    localparam int WORDS      = LINE_BYTES / 4;
    localparam logic [2:0] M_B = 3'b000, M_H = 3'b001, M_W = 3'b010, M_BU = 3'b100, M_HU = 3'b101;

    logic              clk, rst;
    logic              req_valid, req_ready, req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_mode;
    logic [31:0]       req_wdata;
    logic              resp_valid, resp_fault;
    logic [31:0]       resp_rdata;
    logic              mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
    logic [3:0]        mem_be;

    dcache_dm #(.ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .LINES(LINES)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_mode(req_mode), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;

    int checks = 0;
    int errors = 0;
    beat_t beats[$];
    logic [7:0] mem_b [logic [31:0]];
    logic [7:0] ref_b [logic [31:0]];
    bit          lv [LINES];
    logic [31:0] lt [LINES];
    int ack_total = 0;
    int ack_limit = 32'h7FFF_FFFF;
    bit force_ack = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] mb(input logic [31:0] a);
        return mem_b.exists(a) ? mem_b[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] rb(input logic [31:0] a);
        return ref_b.exists(a) ? ref_b[a] : init_byte(a);
    endfunction

    task automatic preload_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            mem_b[a + i] = 8'(w >> (8 * (3 - i)));
            ref_b[a + i] = 8'(w >> (8 * (3 - i)));
        end
    endtask

    // Backing memory: random ack latency, logs each beat, checks hold and inter-beat gap.
    initial begin
        int wait_cnt;
        bit acked, stalled;
        logic [31:0] held_addr;
        wait_cnt = 0; acked = 0; stalled = 0; held_addr = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'b0;
        forever begin
            @(negedge clk);
            if (acked) check("mem_req_gap", 32'(mem_req), 0);
            if (stalled) begin
                check("mem_req_hold", 32'(mem_req), 1);
                check("mem_addr_hold", mem_addr, held_addr);
            end
            acked = 0;
            stalled = 0;
            mem_ack = 1'b0;
            mem_rdata = 32'b0;
            if (force_ack) begin
                mem_ack = 1'b1;
            end else if (mem_req && ack_total < ack_limit) begin
                if (wait_cnt > 0) begin
                    wait_cnt--;
                    stalled = 1;
                    held_addr = mem_addr;
                end else begin
                    mem_ack = 1'b1;
                    acked = 1;
                    ack_total++;
                    beats.push_back('{mem_addr, mem_we, mem_be, mem_wdata});
                    if (mem_we) begin
                        for (int i = 0; i < 4; i++)
                            if (mem_be[3-i]) mem_b[mem_addr + i] = mem_wdata[31-8*i -: 8];
                    end else begin
                        mem_rdata = {mb(mem_addr), mb(mem_addr + 1), mb(mem_addr + 2), mb(mem_addr + 3)};
                    end
                    wait_cnt = $urandom_range(0, 2);
                end
            end
        end
    end

    task automatic do_req(input logic [31:0] a, input bit w, input logic [2:0] m, input logic [31:0] wd,
                          output logic [31:0] rd, output logic flt, output int lat, output bit to);
        int n;
        to = 0; rd = 0; flt = 0; lat = 0; n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) to = 1;
        req_valid = 1'b1; req_addr = a; req_write = w; req_mode = m; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        while (!to) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
            if (lat >= 400) to = 1;
        end
        rd = resp_rdata;
        flt = resp_fault;
    endtask

    // One transaction: predict from the access rules, run it, compare everything.
    task automatic step(input logic [31:0] a, input bit w, input logic [2:0] m, input logic [31:0] wd,
                        output logic [31:0] rd);
        int n, li, exp_beats, lat, lane;
        bit legal, flt_e, hit, to;
        logic flt;
        logic [31:0] la, v, base, exp_word, mask;
        logic [3:0] exp_be;
        n = (m[1:0] == 2'b00) ? 1 : (m[1:0] == 2'b01) ? 2 : 4;
        legal = w ? (m inside {M_B, M_H, M_W}) : (m inside {M_B, M_H, M_W, M_BU, M_HU});
        flt_e = !legal || ((int'(a[1:0]) % n) != 0);
        la = a / LINE_BYTES;
        li = int'(la % LINES);
        base = a & ~32'(LINE_BYTES - 1);
        hit = lv[li] && (lt[li] == la);
        exp_beats = flt_e ? 0 : (w ? 1 : (hit ? 0 : WORDS));
        beats.delete();
        do_req(a, w, m, wd, rd, flt, lat, to);
        check("resp_timeout", 32'(to), 0);
        if (to) finish_sim();
        check("fault", 32'(flt), 32'(flt_e));
        check("beats", beats.size(), exp_beats);
        v = 0;
        if (!flt_e && !w) begin
            for (int i = 0; i < n; i++) v = (v << 8) | 32'(rb(a + i));
            if (!m[2] && n < 4 && v[8*n-1]) v |= ~((32'h1 << (8 * n)) - 32'h1);
            lv[li] = 1;
            lt[li] = la;
        end
        check("rdata", rd, v);
        if (flt_e || (!w && hit)) check("latency", lat, 2);
        if (!flt_e && !w && !hit && beats.size() == WORDS) begin
            for (int k = 0; k < WORDS; k++) begin
                check("refill_addr", beats[k].addr, base + 32'(4 * k));
                check("refill_we_be", {beats[k].we, beats[k].be}, 5'b01111);
            end
        end
        if (!flt_e && w) begin
            exp_be = 4'b0000;
            exp_word = 0;
            for (int i = 0; i < n; i++) begin
                lane = int'(a[1:0]) + i;
                exp_be[3-lane] = 1'b1;
                exp_word[31-8*lane -: 8] = 8'(wd >> (8 * (n - 1 - i)));
                ref_b[a + i] = 8'(wd >> (8 * (n - 1 - i)));
            end
            if (beats.size() == 1) begin
                mask = {{8{exp_be[3]}}, {8{exp_be[2]}}, {8{exp_be[1]}}, {8{exp_be[0]}}};
                check("store_addr", beats[0].addr, a & ~32'h3);
                check("store_we_be", {beats[0].we, beats[0].be}, {1'b1, exp_be});
                check("store_wdata", beats[0].wdata & mask, exp_word);
            end
        end
        @(negedge clk);
        check("resp_pulse", 32'(resp_valid), 0);
        check("idle_ready", 32'(req_ready), 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, a;
        logic [2:0] m;
        bit w;
        int n, sel;
        rst = 1'b1; req_valid = 1'b0; req_addr = 0; req_write = 0; req_mode = 0; req_wdata = 0;
        for (int i = 0; i < LINES; i++) begin lv[i] = 0; lt[i] = 0; end
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_fault", 32'(resp_fault), 0);
        check("rst_mem_req", {mem_req, mem_we, mem_be}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;

        preload_word(32'h40, 32'h11223344);
        preload_word(32'h44, 32'h55667788);
        preload_word(32'h48, 32'h99AABBCC);
        preload_word(32'h4C, 32'hDDEEFF00);
        step(32'h40, 0, M_W, 0, rd);          check("t1_rdata", rd, 32'h11223344);
        step(32'h44, 0, M_W, 0, rd);          check("t1_hit_rdata", rd, 32'h55667788);

        step(32'h40, 1, M_W, 32'h80FF0000, rd);
        step(32'h41, 0, M_B, 0, rd);          check("t2_lb", rd, 32'hFFFFFFFF);
        step(32'h41, 0, M_BU, 0, rd);         check("t2_lbu", rd, 32'h000000FF);
        step(32'h40, 0, M_H, 0, rd);          check("t2_lh", rd, 32'hFFFF80FF);
        step(32'h40, 0, M_HU, 0, rd);         check("t2_lhu", rd, 32'h000080FF);

        step(32'h42, 1, M_H, 32'h0000ABCD, rd);
        step(32'h40, 0, M_W, 0, rd);          check("t3_rdata", rd, 32'h80FFABCD);

        step(32'h42, 0, M_W, 0, rd);
        step(32'h40, 1, M_BU, 32'h12, rd);
        step(32'h40, 0, 3'b111, 0, rd);

        step(32'h400, 1, M_W, 32'hDEADBEEF, rd);
        step(32'h400, 0, M_W, 0, rd);         check("t5_rdata", rd, 32'hDEADBEEF);

        // Reset while the third refill beat is outstanding.
        ack_limit = ack_total + 2;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h800; req_write = 0; req_mode = M_W; req_wdata = 0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (!(mem_req && mem_addr == 32'h808) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t6_reach_beat2", mem_addr, 32'h808);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_mem_req", 32'(mem_req), 0);
        check("t6_resp_valid", 32'(resp_valid), 0);
        check("t6_req_ready", 32'(req_ready), 1);
        force_ack = 1;
        ack_limit = 32'h7FFF_FFFF;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("t6_late_ack_resp", 32'(resp_valid), 0);
            check("t6_late_ack_req", 32'(mem_req), 0);
        end
        force_ack = 0;
        for (int i = 0; i < LINES; i++) lv[i] = 0;
        step(32'h800, 0, M_W, 0, rd);

        step(32'hFFFFFFF0, 0, M_W, 0, rd);
        step(32'hFFFFFFFC, 0, M_W, 0, rd);
        step(32'hFFFFFFFF, 0, M_BU, 0, rd);

        for (int t = 0; t < 200; t++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       a = 32'($urandom_range(0, 511));
                1:       a = 32'h400 + 32'($urandom_range(0, 511));
                2:       a = 32'hFFFFFE00 + 32'($urandom_range(0, 511));
                default: a = $urandom;
            endcase
            m = 3'($urandom_range(0, 7));
            w = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) != 0) begin
                if (m[1:0] == 2'b01)      a[0] = 1'b0;
                else if (m[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            step(a, w, m, $urandom, rd);
        end
        finish_sim();
    end

endmodule
